// File: rtl/pipe_fft_dly_pkg.sv
// Shared types, defaults and helper functions for the FFT delay line.
package pipe_fft_dly_pkg;

  localparam int DLY_WIDTH_DEF = 66;
  localparam int DLY_DEPTH_DEF = 2;

  // Widest word the parity helper folds; callers zero-extend into it.
  localparam int PAR_MAX_W = 1024;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/pipe_fft_dly_mem.sv
// Simple dual-port storage: one write port, one registered read port, one clock.
module pipe_fft_dly_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk,
  input  logic             rd_rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // NOTE: the array has no reset so it can map onto block/micro RAM; only the read register is cleared.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // NOTE: non-blocking updates make a same-address read return the old word, which is what sets the delay.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (rd_rst) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pipe_fft_dly_line.sv
// Stallable, flushable delay line of DEPTH enabled cycles with per-word valid tags.
// Define DLY_PARITY_EN to store an even-parity bit per entry and flag sticky read errors.
module pipe_fft_dly_line
  import pipe_fft_dly_pkg::*;
#(
  parameter int WIDTH = DLY_WIDTH_DEF,
  parameter int DEPTH = DLY_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             primed,
  output logic             parity_err
);

  localparam int PW = ptr_w(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
`ifdef DLY_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [DEPTH-1:0] vtag_q, vtag_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             dout_valid_q, dout_valid_d;
  logic             wr_fire;
  logic [MW-1:0]    mem_wdata, mem_rdata;

  // Flush wins over en; reset wins over both and also blocks the memory.
  assign wr_fire = en & ~flush;

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    ptr_d        = ptr_q;
    vtag_d       = vtag_q;
    fill_d       = fill_q;
    dout_valid_d = dout_valid_q;
    if (flush) begin
      ptr_d        = '0;
      vtag_d       = '0;
      fill_d       = '0;
      dout_valid_d = 1'b0;
    end else if (en) begin
      dout_valid_d   = vtag_q[ptr_q];
      vtag_d[ptr_q]  = din_valid;
      ptr_d          = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
      if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      vtag_q       <= '0;
      fill_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      vtag_q       <= vtag_d;
      fill_q       <= fill_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef DLY_PARITY_EN
  assign mem_wdata = {even_par(PAR_MAX_W'(din)), din};

  logic rd_chk_q, rd_chk_d;
  logic parity_err_q, parity_err_d;

  // The check runs on the registered read word, one cycle after a valid entry is read.
  always_comb begin
    rd_chk_d     = wr_fire & vtag_q[ptr_q];
    parity_err_d = parity_err_q |
                   (rd_chk_q & (even_par(PAR_MAX_W'(mem_rdata[WIDTH-1:0])) != mem_rdata[WIDTH]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_chk_q     <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rd_chk_q     <= rd_chk_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign mem_wdata  = din;
  assign parity_err = 1'b0;
`endif

  pipe_fft_dly_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk    (clk),
    .rd_rst (rst),
    .we     (wr_fire & ~rst),
    .waddr  (ptr_q),
    .wdata  (mem_wdata),
    .re     (wr_fire & ~rst),
    .raddr  (ptr_q),
    .rdata  (mem_rdata)
  );

  assign dout       = mem_rdata[WIDTH-1:0];
  assign dout_valid = dout_valid_q;
  assign primed     = (fill_q == FW'(DEPTH));

endmodule

// File: tb/tb_pipe_fft_dly_line.sv
// Scoreboard bench: three delay lines (DEPTH 2/4/1) share stimulus; a FIFO model predicts each output.
module tb_pipe_fft_dly_line;

  localparam int NDUT = 3;
  localparam int DEP [NDUT] = '{2, 4, 1};

  typedef struct {
    logic [65:0] d;
    logic        v;
  } wr_t;

  typedef struct {
    logic [65:0] d;
    bit          known;
    logic        v;
    logic        primed;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [65:0] din = '0;
  logic        din_valid = 1'b0;

  logic [65:0] dout0, dout1;
  logic [7:0]  dout2;
  logic        dv0, dv1, dv2, pr0, pr1, pr2, pe0, pe1, pe2;

  int errors = 0;
  int checks = 0;
  bit sb_en  = 1'b1;

  wr_t         fifo  [NDUT][$];
  exp_t        sb_q  [NDUT][$];
  logic [65:0] cur_d [NDUT];
  bit          cur_k [NDUT];
  logic        cur_v [NDUT];

  always #5 clk = ~clk;

  pipe_fft_dly_line #(.WIDTH(66), .DEPTH(2)) dut0 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_valid(din_valid),
    .dout(dout0), .dout_valid(dv0), .primed(pr0), .parity_err(pe0));

  pipe_fft_dly_line #(.WIDTH(66), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .din_valid(din_valid),
    .dout(dout1), .dout_valid(dv1), .primed(pr1), .parity_err(pe1));

  pipe_fft_dly_line #(.WIDTH(8), .DEPTH(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din[7:0]), .din_valid(din_valid),
    .dout(dout2), .dout_valid(dv2), .primed(pr2), .parity_err(pe2));

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain FIFO of writes since the last reset/flush; the output
  // is the word that has waited DEPTH enabled writes, unknown data before that.
  task automatic model_step(input int i);
    logic [65:0] mask;
    wr_t         w;
    mask = (i == 2) ? 66'hFF : {66{1'b1}};
    if (rst) begin
      fifo[i].delete();
      cur_d[i] = '0;
      cur_k[i] = 1'b1;
      cur_v[i] = 1'b0;
    end else if (flush) begin
      fifo[i].delete();
      cur_v[i] = 1'b0;
    end else if (en) begin
      fifo[i].push_back('{din & mask, din_valid});
      if (fifo[i].size() > DEP[i]) begin
        w        = fifo[i].pop_front();
        cur_d[i] = w.d;
        cur_k[i] = 1'b1;
        cur_v[i] = w.v;
      end else begin
        cur_k[i] = 1'b0;
        cur_v[i] = 1'b0;
      end
    end
    sb_q[i].push_back('{cur_d[i], cur_k[i], cur_v[i], fifo[i].size() == DEP[i]});
  endtask

  task automatic cycle(input logic r, input logic e, input logic f,
                       input logic [65:0] d, input logic v);
    @(negedge clk);
    rst = r; en = e; flush = f; din = d; din_valid = v;
    @(posedge clk);
    if (sb_en) for (int i = 0; i < NDUT; i++) model_step(i);
  endtask

  function automatic logic [65:0] rnd66();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[65:0];
  endfunction

  task automatic compare(input int i, input logic [65:0] ad, input logic av,
                         input logic ap, input logic ape);
    exp_t e;
    e = sb_q[i].pop_front();
    check($sformatf("dut%0d dout_valid", i), 66'(av), 66'(e.v));
    check($sformatf("dut%0d primed", i), 66'(ap), 66'(e.primed));
    check($sformatf("dut%0d parity_err", i), 66'(ape), 66'(1'b0));
    if (e.known) check($sformatf("dut%0d dout", i), ad, e.d);
  endtask

  // Monitor: outputs settle after each posedge; compare at the following negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q[0].size() > 0) compare(0, dout0, dv0, pr0, pe0);
      if (sb_q[1].size() > 0) compare(1, dout1, dv1, pr1, pe1);
      if (sb_q[2].size() > 0) compare(2, 66'(dout2), dv2, pr2, pe2);
    end
  end

  initial begin
    // Reset, then two idle enabled cycles before the 1..4 sequence.
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 0, '0, 0);
    cycle(0, 1, 0, '0, 0);
    cycle(0, 1, 0, '0, 0);
    for (int k = 1; k <= 4; k++) cycle(0, 1, 0, 66'(k), 1);

    // Stall: 0xA, 0xB, five held cycles, then 0xC..0xF.
    cycle(0, 1, 0, 66'hA, 1);
    cycle(0, 1, 0, 66'hB, 1);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, rnd66(), 1);
    for (int k = 12; k <= 15; k++) cycle(0, 1, 0, 66'(k), 1);

    // Flush with en high: the flush-cycle word must not be stored.
    cycle(0, 1, 1, 66'h99, 1);
    for (int k = 0; k < 6; k++) cycle(0, 1, 0, 66'h100 + 66'(k), 1);

    // Reset while stalled, then refill.
    cycle(0, 0, 0, '0, 0);
    cycle(1, 0, 0, rnd66(), 1);
    for (int k = 0; k < 6; k++) cycle(0, 1, 0, 66'h200 + 66'(k), 1);

    // Randomised traffic with occasional stalls, flushes and resets.
    for (int k = 0; k < 600; k++) begin
      automatic int rr = $urandom_range(99, 0);
      cycle(rr == 0, $urandom_range(3, 0) != 0, rr inside {[1:3]}, rnd66(), 1'($urandom));
    end
    cycle(0, 0, 0, '0, 0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) check($sformatf("dut%0d drain", i), 66'(sb_q[i].size()), 66'(0));

`ifdef DLY_PARITY_EN
    sb_en = 1'b0;
    cycle(1, 0, 0, '0, 0);
    cycle(0, 1, 0, 66'h5, 1);
    cycle(0, 1, 0, 66'h6, 1);
    @(negedge clk);
    en = 1'b0;
    dut0.u_mem.mem_q[0][0] = ~dut0.u_mem.mem_q[0][0];
    check("parity clean before read", 66'(pe0), 66'(0));
    cycle(0, 1, 0, '0, 0);
    begin
      automatic int waited = 0;
      while (pe0 !== 1'b1 && waited < 4) begin
        cycle(0, 0, 0, '0, 0);
        @(negedge clk);
        waited++;
      end
    end
    check("parity_err set", 66'(pe0), 66'(1));
    cycle(0, 1, 1, '0, 0);
    @(negedge clk);
    check("parity_err sticky over flush", 66'(pe0), 66'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
